// File: rtl/ysyx_24090013_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode output
// and execute redirect, seen from the IFU (master) or its neighbours (slave).
interface ysyx_24090013_ifu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            rsp_ready;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr, rsp_ready, out_valid, out_inst, out_pc, out_err,
    input  req_ready, rsp_valid, rsp_data, rsp_err, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, out_valid, out_inst, out_pc, out_err,
    output req_ready, rsp_valid, rsp_data, rsp_err, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_24090013_ifu.sv
// Instruction fetch unit: one outstanding word fetch, held result to decode,
// redirect from execute discards whatever fetch is in flight or held.
module ysyx_24090013_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  ysyx_24090013_ifu_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            kill, kill_next;
  logic [31:0]     inst_q, inst_next;
  logic            err_q, err_next;

  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_lsb;

  assign redirect_target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // All outputs are decoded from registered state; only out_valid also sees
  // the redirect so a held instruction cannot escape in the redirect cycle.
  assign bus.req_valid = (state == S_REQ);
  assign bus.req_addr  = pc;
  assign bus.rsp_ready = (state == S_WAIT);
  assign bus.out_valid = (state == S_OUT) && !bus.redirect_valid;
  assign bus.out_inst  = inst_q;
  assign bus.out_pc    = pc;
  assign bus.out_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      kill   <= 1'b0;
      inst_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      kill   <= kill_next;
      inst_q <= inst_next;
      err_q  <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    kill_next  = kill;
    inst_next  = inst_q;
    err_next   = err_q;

    if (bus.redirect_valid) begin
      pc_next = redirect_target;
    end

    unique case (state)
      S_IDLE: begin
        state_next = S_REQ;
      end

      S_REQ: begin
        // A redirect racing the handshake still consumes the slot; the
        // response it produces must be thrown away.
        if (bus.req_ready) begin
          state_next = S_WAIT;
          kill_next  = bus.redirect_valid;
        end
      end

      S_WAIT: begin
        if (bus.rsp_valid) begin
          if (kill || bus.redirect_valid) begin
            kill_next  = 1'b0;
            state_next = S_REQ;
          end else begin
            inst_next  = bus.rsp_data;
            err_next   = bus.rsp_err;
            state_next = S_OUT;
          end
        end else if (bus.redirect_valid) begin
          kill_next = 1'b1;
        end
      end

      S_OUT: begin
        if (bus.redirect_valid) begin
          state_next = S_REQ;
        end else if (bus.out_ready) begin
          pc_next    = pc + XLEN'(4);
          state_next = S_REQ;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090013_ifu.sv
// Randomised bench for the fetch unit: memory/decode/redirect drivers plus a
// program-order scoreboard of expected PCs checked on every decode handshake.
module tb_ysyx_24090013_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  ysyx_24090013_ifu_if #(.XLEN(32)) bus ();

  ysyx_24090013_ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Stimulus knobs, written only by the main sequence.
  bit          mem_rand = 1'b0;
  int          mem_lat = 0;
  bit          hold_req = 1'b0;
  bit          out_rand = 1'b0;
  bit          out_hold = 1'b0;
  bit          redir_rand = 1'b0;
  int          redir_seq = 0;
  logic [31:0] redir_seq_pc = 32'h0;

  // Values sampled by the monitor at the falling edge.
  bit          s_req_fire = 1'b0;
  logic [31:0] s_req_addr = 32'h0;
  bit          s_rsp_fire = 1'b0;
  int          fire_cycles[$];
  int          fire_count = 0;
  logic [31:0] last_out_pc = 32'h0;

  // Expected program order: head is the PC of the next instruction decode must see.
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'h1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return bus.req_valid && !bus.req_ready;
      1: return bus.out_valid && !bus.out_ready;
      2: return bus.rsp_ready && !bus.rsp_valid;
      default: return bus.req_valid;
    endcase
  endfunction

  // Advance falling edges until the condition holds; an expired budget is a failure.
  task automatic wait_cond(input int which, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(which) && n < 200);
    if (!cond(which)) begin
      total_cnt++;
      $display("FAIL %s: timeout waiting, got 0, want 1", name);
    end
  endtask

  task automatic wait_fires(input int target, input string name);
    int n;
    n = 0;
    while (fire_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (fire_count < target) begin
      total_cnt++;
      $display("FAIL %s: timeout, got %0d fires, want %0d", name, fire_count, target);
    end
  endtask

  task automatic request_redirect(input logic [31:0] tgt);
    redir_seq_pc = tgt;
    redir_seq++;
  endtask

  // Instruction memory: one pending read, data and fault derived from the address.
  initial begin
    bit          pend;
    logic [31:0] paddr;
    int          wcnt;
    pend = 1'b0;
    paddr = 32'h0;
    wcnt = 0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = 32'h0;
    bus.rsp_err = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend = 1'b0;
        bus.rsp_valid = 1'b0;
      end else begin
        if (bus.rsp_valid && s_rsp_fire) begin
          bus.rsp_valid = 1'b0;
          pend = 1'b0;
        end
        if (s_req_fire) begin
          pend = 1'b1;
          paddr = s_req_addr;
          wcnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (pend && !bus.rsp_valid) begin
          if (wcnt == 0) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data = mem_data(paddr);
            bus.rsp_err = mem_err(paddr);
          end else begin
            wcnt--;
          end
        end
      end
      bus.req_ready = hold_req ? 1'b0 : (mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Decode-side backpressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = out_hold ? 1'b0 : (out_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Execute redirects: directed ones from the main sequence, random ones otherwise.
  initial begin
    int          seen_seq;
    logic [31:0] tgt;
    bit          fire;
    seen_seq = 0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      fire = 1'b0;
      tgt = 32'h0;
      if (redir_seq != seen_seq) begin
        seen_seq = redir_seq;
        tgt = redir_seq_pc;
        fire = 1'b1;
      end else if (redir_rand && rst_n && $urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        else tgt = RESET_PC + $urandom_range(0, 4095);
        fire = 1'b1;
      end
      bus.redirect_valid = fire;
      bus.redirect_pc = fire ? tgt : $urandom;
      if (fire) begin
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
      end
    end
  end

  // Monitor: samples handshakes and scores every instruction handed to decode.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      s_req_fire = rst_n && bus.req_valid && bus.req_ready;
      s_req_addr = bus.req_addr;
      s_rsp_fire = rst_n && bus.rsp_valid && bus.rsp_ready;
      if (rst_n && bus.req_valid) check("req_align", {30'h0, bus.req_addr[1:0]}, 32'h0);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        fire_cycles.push_back(cycle);
        fire_count++;
        last_out_pc = bus.out_pc;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL sb_empty: got out_pc %h, want no output", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", bus.out_pc, e);
          check("out_inst", bus.out_inst, mem_data(e));
          check("out_err", {31'h0, bus.out_err}, {31'h0, mem_err(e)});
          exp_q.push_back(e + 32'd4);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, pinst, ppc;
    int n0;
    exp_q.push_back(RESET_PC);

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'h0, bus.req_valid}, 32'h0);
    check("rst_rsp_ready", {31'h0, bus.rsp_ready}, 32'h0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_out_err", {31'h0, bus.out_err}, 32'h0);
    check("rst_out_pc", bus.out_pc, RESET_PC);
    check("rst_req_addr", bus.req_addr, RESET_PC);

    // Zero-wait streaming, first request one edge after release.
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_req_early", {31'h0, bus.req_valid}, 32'h0);
    @(negedge clk);
    check("first_req", {31'h0, bus.req_valid}, 32'h1);
    check("first_req_addr", bus.req_addr, RESET_PC);
    repeat (12) @(negedge clk);
    check("zw_fires", {31'h0, fire_cycles.size() >= 3}, 32'h1);
    if (fire_cycles.size() >= 3) begin
      for (int i = 1; i < 3; i++)
        check("zw_interval", fire_cycles[i] - fire_cycles[i-1], 32'd3);
    end

    // Request held off by memory.
    hold_req = 1'b1;
    wait_cond(0, "req_stall_enter");
    a = bus.req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("req_stall_valid", {31'h0, bus.req_valid}, 32'h1);
      check("req_stall_addr", bus.req_addr, a);
      check("req_stall_no_wait", {31'h0, bus.rsp_ready}, 32'h0);
    end
    hold_req = 1'b0;

    // Output held off by decode.
    out_hold = 1'b1;
    wait_cond(1, "out_stall_enter");
    pinst = bus.out_inst;
    ppc = bus.out_pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("out_stall_valid", {31'h0, bus.out_valid}, 32'h1);
      check("out_stall_inst", bus.out_inst, pinst);
      check("out_stall_pc", bus.out_pc, ppc);
      check("out_stall_no_req", {31'h0, bus.req_valid}, 32'h0);
    end
    out_hold = 1'b0;

    // Redirect while waiting on a slow response; that response must vanish.
    mem_lat = 3;
    wait_cond(2, "wait_redir_enter");
    request_redirect(32'h8000_0102);
    @(negedge clk);
    n0 = fire_count;
    wait_cond(3, "wait_redir_req");
    check("wait_redir_req_addr", bus.req_addr, 32'h8000_0100);
    mem_lat = 0;
    wait_fires(n0 + 1, "wait_redir_out");
    check("wait_redir_out_pc", last_out_pc, 32'h8000_0100);

    // Redirect in the same cycle decode becomes ready.
    out_hold = 1'b1;
    wait_cond(1, "out_redir_enter");
    out_hold = 1'b0;
    request_redirect(32'h8000_0200);
    @(negedge clk);
    check("out_redir_gate", {31'h0, bus.out_valid}, 32'h0);
    n0 = fire_count;
    wait_cond(3, "out_redir_req");
    check("out_redir_req_addr", bus.req_addr, 32'h8000_0200);
    wait_fires(n0 + 1, "out_redir_out");
    check("out_redir_out_pc", last_out_pc, 32'h8000_0200);

    // PC wraps past the top of the address space.
    request_redirect(32'hFFFF_FFFE);
    @(negedge clk);
    n0 = fire_count;
    wait_fires(n0 + 2, "wrap_out");
    check("wrap_out_pc", last_out_pc, 32'h0000_0000);

    // Fully randomised traffic.
    mem_rand = 1'b1;
    out_rand = 1'b1;
    redir_rand = 1'b1;
    n0 = fire_count;
    repeat (4000) @(negedge clk);
    redir_rand = 1'b0;
    repeat (40) @(negedge clk);
    check("rand_progress", {31'h0, (fire_count - n0) > 200}, 32'h1);

    // Reset in the middle of traffic.
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    @(negedge clk);
    check("midrst_req_valid", {31'h0, bus.req_valid}, 32'h0);
    check("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("midrst_out_pc", bus.out_pc, RESET_PC);
    check("midrst_req_addr", bus.req_addr, RESET_PC);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = fire_count;
    wait_fires(n0 + 1, "midrst_out");
    check("midrst_first_pc", last_out_pc, RESET_PC);
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
